// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } icache_state_t;

  localparam int NLINES_DEFAULT = 16;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one synchronous write,
// synchronous clear of all valid bits (a same-edge write wins for its line).
module icache_array
  import icache_pkg::*;
#(
  parameter int NLINES = NLINES_DEFAULT,
  parameter int IW     = $clog2(NLINES),
  parameter int TW     = 30 - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_all_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic [31:0]   wr_data_i
);

  logic [NLINES-1:0] valid_q;
  logic [TW-1:0]     tag_q  [NLINES];
  logic [31:0]       data_q [NLINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {NLINES{1'b0}};
    end else begin
      if (clr_all_i) begin
        valid_q <= {NLINES{1'b0}};
      end
      if (wr_en_i) begin
        valid_q[wr_idx_i] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hits, a blocking refill
// sequence IDLE -> FETCH -> FILL on a miss, and a wrapping miss counter.
module icache
  import icache_pkg::*;
#(
  parameter int NLINES = NLINES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        icstall,
  input  logic        icflush,
  output logic        memreq,
  output logic [31:0] memaddr,
  input  logic        memack,
  input  logic [31:0] memrdata,
  output logic [15:0] nmiss
);

  localparam int IW = $clog2(NLINES);
  localparam int TW = 30 - IW;

  icache_state_t state_q;
  logic          memreq_q;
  logic [31:0]   memaddr_q;
  logic [31:0]   fill_q;
  logic [15:0]   nmiss_q;

  logic          rd_valid_s;
  logic [TW-1:0] rd_tag_s;
  logic [31:0]   rd_data_s;
  logic          hit_s;
  logic          unused_s;

  assign unused_s = ^{pcF[1:0], memaddr_q[1:0]};

  // The refill line's index and tag come from the latched request address.
  icache_array #(.NLINES(NLINES)) u_array (
    .clk        (clk),
    .reset      (reset),
    .clr_all_i  (icflush),
    .rd_idx_i   (pcF[IW+1:2]),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_data_o  (rd_data_s),
    .wr_en_i    (state_q == FILL),
    .wr_idx_i   (memaddr_q[IW+1:2]),
    .wr_tag_i   (memaddr_q[31:IW+2]),
    .wr_data_i  (fill_q)
  );

  assign hit_s = (state_q == IDLE) && rd_valid_s && (rd_tag_s == pcF[31:IW+2]);

  always_comb begin
    icstall = 1'b1;
    instrF  = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          icstall = 1'b0;
          instrF  = rd_data_s;
        end else begin
          icstall = 1'b1;
        end
      end
      FETCH: icstall = 1'b1;
      FILL: begin
        icstall = 1'b0;
        instrF  = fill_q;
      end
      default: icstall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      memreq_q  <= 1'b0;
      memaddr_q <= 32'h0000_0000;
      fill_q    <= 32'h0000_0000;
      nmiss_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit_s) begin
            state_q   <= FETCH;
            memreq_q  <= 1'b1;
            memaddr_q <= {pcF[31:2], 2'b00};
            nmiss_q   <= nmiss_q + 16'd1;
          end
        end
        FETCH: begin
          if (memack) begin
            fill_q   <= memrdata;
            memreq_q <= 1'b0;
            state_q  <= FILL;
          end
        end
        FILL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memreq  = memreq_q;
  assign memaddr = memaddr_q;
  assign nmiss   = nmiss_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a transaction-level cache model predicts every
// cycle of each fetch; one negedge process compares the DUT against it.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        icstall;
  logic        icflush;
  logic        memreq;
  logic [31:0] memaddr;
  logic        memack;
  logic [31:0] memrdata;
  logic [15:0] nmiss;

  always #5 clk = ~clk;

  icache #(.NLINES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .pcF      (pcF),
    .instrF   (instrF),
    .icstall  (icstall),
    .icflush  (icflush),
    .memreq   (memreq),
    .memaddr  (memaddr),
    .memack   (memack),
    .memrdata (memrdata),
    .nmiss    (nmiss)
  );

  // Model: what lines the cache holds, plus miss count and last refill address.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [15:0] m_nmiss;
  logic [31:0] m_addr;

  logic        exp_stall;
  logic [31:0] exp_instr;
  logic        exp_memreq;
  logic [31:0] exp_memaddr;
  logic [15:0] exp_nmiss;
  bit          chk_en = 1'b0;
  int          stall_cnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("icstall", {31'd0, icstall}, {31'd0, exp_stall});
      chk("instrF", instrF, exp_instr);
      chk("memreq", {31'd0, memreq}, {31'd0, exp_memreq});
      chk("memaddr", memaddr, exp_memaddr);
      chk("nmiss", {16'd0, nmiss}, {16'd0, exp_nmiss});
      if (icstall) stall_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_nmiss = 16'd0;
    m_addr  = 32'd0;
  endtask

  task automatic expect_cycle(input logic st, input logic [31:0] ins, input logic rq);
    exp_stall   = st;
    exp_instr   = ins;
    exp_memreq  = rq;
    exp_memaddr = m_addr;
    exp_nmiss   = m_nmiss;
  endtask

  // One fetch of pc. flush_at: 1 = flush in first cycle, 2 = flush in FILL.
  // spur: memack in the first (IDLE) cycle. rst_at: reset in that FETCH cycle.
  task automatic fetch(input logic [31:0] pc, input int k, input logic [31:0] data,
                       input int flush_at, input bit spur, input int rst_at);
    int          idx;
    logic [25:0] tag;
    idx       = int'(pc[5:2]);
    tag       = pc[31:6];
    stall_cnt = 0;
    pcF       = pc;
    icflush   = (flush_at == 1);
    memack    = spur;
    memrdata  = 32'hDEAD_BEEF;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      expect_cycle(1'b0, m_data[idx], 1'b0);
      step();
      icflush = 1'b0;
      memack  = 1'b0;
      if (flush_at == 1) model_clear();
    end else begin
      expect_cycle(1'b1, 32'd0, 1'b0);
      step();
      icflush = 1'b0;
      memack  = 1'b0;
      if (flush_at == 1) model_clear();
      m_nmiss = m_nmiss + 16'd1;
      m_addr  = {pc[31:2], 2'b00};
      for (int c = 1; c <= k; c++) begin
        expect_cycle(1'b1, 32'd0, 1'b1);
        memack   = (c == k);
        memrdata = data;
        reset    = (c == rst_at);
        step();
        memack = 1'b0;
        if (c == rst_at) begin
          reset = 1'b0;
          model_reset();
          return;
        end
      end
      expect_cycle(1'b0, data, 1'b0);
      icflush  = (flush_at == 2);
      memrdata = 32'h0BAD_0BAD;
      step();
      icflush = 1'b0;
      if (flush_at == 2) model_clear();
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_data[idx]  = data;
    end
  endtask

  initial begin
    reset    = 1'b1;
    pcF      = 32'h0000_0040;
    icflush  = 1'b0;
    memack   = 1'b0;
    memrdata = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    expect_cycle(1'b1, 32'd0, 1'b0);
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    // Cold miss with memack in the third request cycle.
    fetch(32'h0000_0040, 3, 32'h1111_AAAA, 0, 1'b0, 0);
    chk("lit_stall_k3", stall_cnt, 32'd4);
    chk("lit_memaddr", memaddr, 32'h0000_0040);
    chk("lit_nmiss1", {16'd0, nmiss}, 32'd1);

    // Same address now hits with zero latency.
    fetch(32'h0000_0040, 1, 32'h0, 0, 1'b0, 0);
    chk("lit_hit_stall", stall_cnt, 32'd0);
    chk("lit_hit_instr", instrF, 32'h1111_AAAA);

    // Conflict on index 0.
    fetch(32'h0000_0080, 2, 32'h2222_BBBB, 0, 1'b0, 0);
    fetch(32'h0000_0040, 1, 32'h3333_CCCC, 0, 1'b0, 0);
    chk("lit_stall_k1", stall_cnt, 32'd2);
    chk("lit_nmiss3", {16'd0, nmiss}, 32'd3);

    // Flush during a hit, then the same address misses.
    fetch(32'h0000_0040, 1, 32'h0, 1, 1'b0, 0);
    fetch(32'h0000_0040, 2, 32'h4444_DDDD, 0, 1'b0, 0);
    chk("lit_nmiss4", {16'd0, nmiss}, 32'd4);

    // Flush coinciding with a FILL write keeps only the filled line.
    fetch(32'h0000_0044, 1, 32'h5555_EEEE, 0, 1'b0, 0);
    fetch(32'h0000_0080, 2, 32'h6666_FFFF, 2, 1'b0, 0);
    fetch(32'h0000_0080, 1, 32'h0, 0, 1'b0, 0);
    fetch(32'h0000_0044, 1, 32'h7777_0001, 0, 1'b0, 0);
    chk("lit_nmiss7", {16'd0, nmiss}, 32'd7);

    // Reset in the second FETCH cycle, then a spurious memack in IDLE.
    fetch(32'h0000_0040, 3, 32'h8888_0002, 0, 1'b0, 2);
    fetch(32'h0000_0040, 2, 32'h9999_0003, 0, 1'b1, 0);
    chk("lit_nmiss_after_rst", {16'd0, nmiss}, 32'd1);
    fetch(32'h0000_0080, 1, 32'hAAAA_0004, 0, 1'b0, 0);
    fetch(32'h0000_0044, 1, 32'hBBBB_0005, 0, 1'b0, 0);
    fetch(32'h0000_0044, 1, 32'h0, 0, 1'b0, 0);
    chk("lit_instr_44", instrF, 32'hBBBB_0005);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NLINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: pcF  input  32  fetch address from datapath; bits [1:0] ignored.
REQ-005 Port: instrF  output  32  instruction word to datapath fetch stage.
REQ-006 Port: icstall  output  1  fetch stall; datapath holds pcF and the fetch/decode registers while high.
REQ-007 Port: icflush  input  1  invalidate all lines (single-cycle pulse).
REQ-008 Port: memreq  output  1  refill request to main memory.
REQ-009 Port: memaddr  output  32  word-aligned refill address.
REQ-010 Port: memack  input  1  one-cycle pulse; memrdata is valid in that cycle.
REQ-011 Port: memrdata  input  32  refill data.
REQ-012 Port: nmiss  output  16  miss counter, wraps at 16'hFFFF to 0.

Function
REQ-013 Address split: index = pcF[IW+1:2], IW = log2(NLINES); tag = pcF[31:IW+2].
REQ-014 Hit (IDLE, line valid, tag equal): instrF = line data combinationally; icstall = 0; zero-cycle latency.
REQ-015 FSM states are IDLE, FETCH and FILL.
REQ-016 IDLE on miss: icstall = 1 in the same cycle; next edge -> FETCH, memreq <= 1, memaddr <= {pcF[31:2],2'b00}, nmiss increments by 1.
REQ-017 FETCH: memreq and memaddr hold stable and icstall = 1 until memack; on memack, memrdata is latched into a fill register, memreq <= 0, state -> FILL.
REQ-018 FILL: data, tag and valid bit are written at the index; instrF = fill register; icstall = 0; next edge -> IDLE.
REQ-019 Miss penalty: with memack k cycles after memreq rises (k >= 1), icstall is high for k+1 cycles; pcF is delivered in the FILL cycle.
REQ-020 pcF is stable while icstall = 1, because the datapath holds it; the cache neither samples nor checks pcF in FETCH.
REQ-021 memack outside FETCH is ignored.
REQ-022 icflush clears every valid bit at the next edge in any state; an in-flight refill still completes, and its FILL write takes priority over the flush for that line when both fall on the same edge.
REQ-023 In FILL, instrF is driven from the fill register and the array lookup is not used.
REQ-024 When not hit and not FILL, instrF = 32'h0.

Reset
REQ-025 At a reset edge: state <= IDLE, all valid bits <= 0, memreq <= 0, memaddr <= 0, nmiss <= 0, fill register <= 0.
REQ-026 Reset asserted in FETCH drops memreq at that edge and abandons the refill; memack arriving after reset is ignored (REQ-021).
REQ-027 Tag and data arrays are not reset; only the valid bits are.

Structure
REQ-028 Shared package icache_pkg holds the state enum icache_state_t (IDLE, FETCH, FILL) and the default NLINES constant.
REQ-029 Sub-module icache_array holds valid, tag and data storage, with a combinational read port, one synchronous write port and a synchronous clear-all of the valid bits.
REQ-030 Top-level icache contains the FSM, memaddr/memreq registers, fill register and nmiss counter.

Verification
REQ-031 After reset, pcF=32'h0000_0040 with memack 3 cycles after memreq: memaddr=32'h40, icstall high 4 cycles, instrF=memrdata in FILL, nmiss=1.
REQ-032 Repeat pcF=32'h40 after that fill: icstall=0 and instrF correct in the same cycle, nmiss unchanged.
REQ-033 Conflict: pcF=32'h40 and then 32'h80 (same index, NLINES=16): second access misses, and a return to 32'h40 misses again, so nmiss=3.
REQ-034 icflush pulse after REQ-032: the next pcF=32'h40 misses and nmiss increments.
REQ-035 Reset in the second FETCH cycle followed by a spurious memack: memreq=0 and state IDLE; no line becomes valid, and pcF=32'h40 then misses.
REQ-036 icflush in the same cycle as the FILL write: only that line is valid afterward; any other previously valid line misses.
